// File: rtl/hart_run_ctrl_pkg.sv
// Shared definitions for the hart run-state controller.
// Holds the per-hart state encoding used by the FSM, the top-level debug port
// and the testbench.
package hart_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_WAKE  = 2'd2,
        ST_HALT  = 2'd3
    } hart_state_e;

    localparam int HART_STATE_W = 2;

endpackage

// File: rtl/hart_run_fsm.sv
// One hart's run-state machine: RUN / SLEEP / WAKE / HALT, the captured
// sleep PC and the enable-qualified delayed stall.
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   i_clk_en           global enable; state only advances when high
//   i_halt_req         halt retired in writeback (highest priority)
//   i_sleep_req        sleep instruction valid in execute
//   i_sleep_pc         PC to resume at, captured on RUN -> SLEEP
//   i_irq_state/mask   pending interrupts and wake mask
//   i_irq_taken        interrupt reached writeback; leaves WAKE
//   i_stall_in         execute-stage stall
//   o_stall_d          stall_in delayed by one enabled cycle
//   o_halted/o_sleeping/o_halt_or_sleep/o_wake_pending  state decodes
//   o_resume_pc        captured sleep PC
//   o_state            raw state for debug/observation
module hart_run_fsm
    import hart_run_ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IRQ_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clk_en,
    input  logic             i_halt_req,
    input  logic             i_sleep_req,
    input  logic [PC_W-1:0]  i_sleep_pc,
    input  logic [IRQ_W-1:0] i_irq_state,
    input  logic [IRQ_W-1:0] i_irq_mask,
    input  logic             i_irq_taken,
    input  logic             i_stall_in,
    output logic             o_stall_d,
    output logic             o_halted,
    output logic             o_sleeping,
    output logic             o_halt_or_sleep,
    output logic             o_wake_pending,
    output logic [PC_W-1:0]  o_resume_pc,
    output hart_state_e      o_state
);

    hart_state_e       r_state;
    hart_state_e       w_state_next;
    logic [PC_W-1:0]   r_resume_pc;
    logic [PC_W-1:0]   w_resume_pc_next;
    logic              r_stall_d;
    logic              w_wake;

    assign w_wake = |(i_irq_state & i_irq_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_resume_pc <= '0;
            r_stall_d   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_resume_pc <= w_resume_pc_next;
            if (i_clk_en) begin
                r_stall_d <= i_stall_in;
            end
        end
    end

    // halt_req beats everything; irq_taken only matters in WAKE, and the wake
    // condition is only looked at once already in SLEEP, so a wake arriving
    // together with sleep_req still costs one enabled cycle asleep.
    always_comb begin
        w_state_next     = r_state;
        w_resume_pc_next = r_resume_pc;
        if (i_clk_en) begin
            case (r_state)
                ST_RUN: begin
                    if (i_halt_req) begin
                        w_state_next = ST_HALT;
                    end else if (i_sleep_req) begin
                        w_state_next     = ST_SLEEP;
                        w_resume_pc_next = i_sleep_pc;
                    end
                end
                ST_SLEEP: begin
                    if (i_halt_req) begin
                        w_state_next = ST_HALT;
                    end else if (w_wake) begin
                        w_state_next = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (i_halt_req) begin
                        w_state_next = ST_HALT;
                    end else if (i_irq_taken) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    assign o_state         = r_state;
    assign o_halted        = (r_state == ST_HALT);
    assign o_sleeping      = (r_state == ST_SLEEP);
    assign o_wake_pending  = (r_state == ST_WAKE);
    assign o_halt_or_sleep = (r_state == ST_HALT) || (r_state == ST_SLEEP);
    assign o_resume_pc     = r_resume_pc;
    assign o_stall_d       = r_stall_d;

endmodule

// File: rtl/hart_run_ctrl.sv
// Run-state controller for the pipelined core: a free-running clock-enable
// divider plus one independent halt/sleep/wake FSM per hart.
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   clock_divider    clk_en pulses once every clock_divider+1 cycles
//   clk_en           global enable; all hart updates qualify on it
//   halt_req, sleep_req, sleep_pc, irq_state, irq_mask, irq_taken, stall_in
//                    per-hart inputs, packed hart-major
//   stall_d, halted, sleeping, halt_or_sleep, wake_pending, resume_pc
//                    per-hart registered outputs
//   all_halted       every hart is in HALT
//   dbg_state        per-hart raw state (2 bits each, hart_state_e encoding)
module hart_run_ctrl
    import hart_run_ctrl_pkg::*;
#(
    parameter int NUM_HARTS = 1,
    parameter int PC_W      = 32,
    parameter int IRQ_W     = 16,
    parameter int DIV_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DIV_W-1:0]               clock_divider,
    output logic                           clk_en,
    input  logic [NUM_HARTS-1:0]           halt_req,
    input  logic [NUM_HARTS-1:0]           sleep_req,
    input  logic [NUM_HARTS*PC_W-1:0]      sleep_pc,
    input  logic [NUM_HARTS*IRQ_W-1:0]     irq_state,
    input  logic [NUM_HARTS*IRQ_W-1:0]     irq_mask,
    input  logic [NUM_HARTS-1:0]           irq_taken,
    input  logic [NUM_HARTS-1:0]           stall_in,
    output logic [NUM_HARTS-1:0]           stall_d,
    output logic [NUM_HARTS-1:0]           halted,
    output logic [NUM_HARTS-1:0]           sleeping,
    output logic [NUM_HARTS-1:0]           halt_or_sleep,
    output logic [NUM_HARTS-1:0]           wake_pending,
    output logic [NUM_HARTS*PC_W-1:0]      resume_pc,
    output logic                           all_halted,
    output logic [NUM_HARTS*HART_STATE_W-1:0] dbg_state
);

    localparam logic [DIV_W-1:0] L_CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_count;
    logic             r_clk_en;

    // Runs on every clock, never gated by its own enable. Using >= rather
    // than == means lowering the divider below the current count produces
    // a pulse on the very next cycle instead of wrapping the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_clk_en <= 1'b1;
        end else if (r_count >= clock_divider) begin
            r_count  <= '0;
            r_clk_en <= 1'b1;
        end else begin
            r_count  <= r_count + L_CNT_ONE;
            r_clk_en <= 1'b0;
        end
    end

    assign clk_en = r_clk_en;

    genvar g;
    generate
        for (g = 0; g < NUM_HARTS; g++) begin : g_hart
            hart_state_e w_state;

            hart_run_fsm #(
                .PC_W  (PC_W),
                .IRQ_W (IRQ_W)
            ) u_fsm (
                .clk             (clk),
                .rst_n           (rst_n),
                .i_clk_en        (r_clk_en),
                .i_halt_req      (halt_req[g]),
                .i_sleep_req     (sleep_req[g]),
                .i_sleep_pc      (sleep_pc[g*PC_W +: PC_W]),
                .i_irq_state     (irq_state[g*IRQ_W +: IRQ_W]),
                .i_irq_mask      (irq_mask[g*IRQ_W +: IRQ_W]),
                .i_irq_taken     (irq_taken[g]),
                .i_stall_in      (stall_in[g]),
                .o_stall_d       (stall_d[g]),
                .o_halted        (halted[g]),
                .o_sleeping      (sleeping[g]),
                .o_halt_or_sleep (halt_or_sleep[g]),
                .o_wake_pending  (wake_pending[g]),
                .o_resume_pc     (resume_pc[g*PC_W +: PC_W]),
                .o_state         (w_state)
            );

            assign dbg_state[g*HART_STATE_W +: HART_STATE_W] = w_state;
        end
    endgenerate

    // Only combinational output: an AND over already-registered bits.
    assign all_halted = &halted;

endmodule

// File: tb/tb_hart_run_ctrl.sv
// Bench for hart_run_ctrl with two harts: directed scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_hart_run_ctrl;
    import hart_run_ctrl_pkg::*;

    localparam int NH    = 2;
    localparam int PC_W  = 32;
    localparam int IRQ_W = 16;
    localparam int DIV_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [DIV_W-1:0]       clock_divider;
    logic                   clk_en;
    logic [NH-1:0]          halt_req, sleep_req, irq_taken, stall_in;
    logic [NH*PC_W-1:0]     sleep_pc;
    logic [NH*IRQ_W-1:0]    irq_state, irq_mask;
    logic [NH-1:0]          stall_d, halted, sleeping, halt_or_sleep, wake_pending;
    logic [NH*PC_W-1:0]     resume_pc;
    logic                   all_halted;
    logic [NH*2-1:0]        dbg_state;

    hart_run_ctrl #(
        .NUM_HARTS (NH),
        .PC_W      (PC_W),
        .IRQ_W     (IRQ_W),
        .DIV_W     (DIV_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clock_divider (clock_divider),
        .clk_en        (clk_en),
        .halt_req      (halt_req),
        .sleep_req     (sleep_req),
        .sleep_pc      (sleep_pc),
        .irq_state     (irq_state),
        .irq_mask      (irq_mask),
        .irq_taken     (irq_taken),
        .stall_in      (stall_in),
        .stall_d       (stall_d),
        .halted        (halted),
        .sleeping      (sleeping),
        .halt_or_sleep (halt_or_sleep),
        .wake_pending  (wake_pending),
        .resume_pc     (resume_pc),
        .all_halted    (all_halted),
        .dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    hart_state_e     m_state  [NH];
    logic [PC_W-1:0] m_resume [NH];
    logic            m_stall  [NH];
    int unsigned     m_since;       // cycles since the last enable pulse
    logic            m_en;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Rule table in priority order: HALT absorbs and halt_req wins; WAKE
    // leaves only on irq_taken; SLEEP leaves on a masked interrupt; RUN
    // sleeps on request.
    function automatic hart_state_e rule_next(hart_state_e s, logic halt, logic slp,
                                              logic wake, logic taken);
        if (s == ST_HALT || halt) return ST_HALT;
        if (s == ST_WAKE)         return taken ? ST_RUN : ST_WAKE;
        if (s == ST_SLEEP)        return wake ? ST_WAKE : ST_SLEEP;
        return slp ? ST_SLEEP : ST_RUN;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_state[h]  = ST_RUN;
            m_resume[h] = '0;
            m_stall[h]  = 1'b0;
        end
        m_since = 0;
        m_en    = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_step();
        hart_state_e ns;
        if (m_en) begin
            for (int h = 0; h < NH; h++) begin
                ns = rule_next(m_state[h], halt_req[h], sleep_req[h],
                               |(irq_state[h*IRQ_W +: IRQ_W] & irq_mask[h*IRQ_W +: IRQ_W]),
                               irq_taken[h]);
                if (m_state[h] == ST_RUN && ns == ST_SLEEP)
                    m_resume[h] = sleep_pc[h*PC_W +: PC_W];
                m_state[h] = ns;
                m_stall[h] = stall_in[h];
            end
        end
        // The enable fires once the gap since the last pulse has reached
        // the divider value (immediately if the divider was lowered).
        if (64'(m_since) >= 64'(clock_divider)) begin
            m_since = 0;
            m_en    = 1'b1;
        end else begin
            m_since = m_since + 1;
            m_en    = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic all_h;
        all_h = 1'b1;
        check({tag, ".clk_en"}, clk_en, m_en);
        for (int h = 0; h < NH; h++) begin
            all_h = all_h & (m_state[h] == ST_HALT);
            check($sformatf("%s.state%0d", tag, h), dbg_state[h*2 +: 2], m_state[h]);
            check($sformatf("%s.halted%0d", tag, h), halted[h], m_state[h] == ST_HALT);
            check($sformatf("%s.sleeping%0d", tag, h), sleeping[h], m_state[h] == ST_SLEEP);
            check($sformatf("%s.wake%0d", tag, h), wake_pending[h], m_state[h] == ST_WAKE);
            check($sformatf("%s.hos%0d", tag, h), halt_or_sleep[h],
                  (m_state[h] == ST_HALT) || (m_state[h] == ST_SLEEP));
            check($sformatf("%s.rpc%0d", tag, h), resume_pc[h*PC_W +: PC_W], m_resume[h]);
            check($sformatf("%s.stall%0d", tag, h), stall_d[h], m_stall[h]);
        end
        check({tag, ".all_halted"}, all_halted, all_h);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input string tag);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic inputs_idle();
        halt_req  = '0;
        sleep_req = '0;
        irq_taken = '0;
        stall_in  = '0;
        sleep_pc  = '0;
        irq_state = '0;
        irq_mask  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(negedge clk);
        check_all("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        clock_divider = 32'd3;
        inputs_idle();
        model_reset();
        @(negedge clk);
        check_all("reset");
        check("reset_clk_en", clk_en, 1'b1);
        rst_n = 1'b1;

        // 1: divider 3 -> pulse on cycle 0 then every 4th cycle
        for (int k = 1; k < 12; k++) begin
            tick("t1_div3");
            check($sformatf("t1_div3_en_c%0d", k), clk_en, (k % 4) == 0);
        end
        clock_divider = 32'd0;
        tick("t1_div0_first");
        for (int k = 0; k < 6; k++) begin
            tick("t1_div0");
            check("t1_div0_en", clk_en, 1'b1);
        end

        // 2: sleep, masked wake, irq_taken
        sleep_req[0] = 1'b1;
        sleep_pc[31:0] = 32'h1000;
        tick("t2_sleep");
        check("t2_sleeping", sleeping[0], 1'b1);
        check("t2_resume_pc", resume_pc[31:0], 32'h1000);
        sleep_pc[31:0] = 32'hDEAD;
        tick("t2_sleep_ignored");
        check("t2_resume_held", resume_pc[31:0], 32'h1000);
        sleep_req[0] = 1'b0;
        irq_state[15:0] = 16'h0004;
        irq_mask[15:0]  = 16'hFFFF;
        tick("t2_wake");
        check("t2_wake_pending", wake_pending[0], 1'b1);
        check("t2_not_sleeping", sleeping[0], 1'b0);
        irq_state[15:0] = 16'h0000;
        irq_taken[0] = 1'b1;
        tick("t2_taken");
        check("t2_run", dbg_state[1:0], ST_RUN);
        irq_taken[0] = 1'b0;

        // wake present together with sleep_req: one enabled cycle asleep first
        sleep_req[0] = 1'b1;
        irq_state[15:0] = 16'h0004;
        tick("t2_same_cycle");
        check("t2_same_cycle_sleep", sleeping[0], 1'b1);
        sleep_req[0] = 1'b0;
        tick("t2_same_cycle_wake");
        check("t2_same_cycle_woke", wake_pending[0], 1'b1);
        irq_state[15:0] = 16'h0000;
        irq_taken[0] = 1'b1;
        tick("t2_back_run");
        irq_taken[0] = 1'b0;

        // 3: masked line does not wake
        sleep_req[0] = 1'b1;
        tick("t3_sleep");
        sleep_req[0] = 1'b0;
        irq_state[15:0] = 16'h0010;
        irq_mask[15:0]  = 16'hFFEF;
        for (int k = 0; k < 20; k++) tick("t3_masked");
        check("t3_still_sleeping", sleeping[0], 1'b1);
        irq_mask[15:0] = 16'hFFFF;
        tick("t3_unmask");
        check("t3_woke", wake_pending[0], 1'b1);
        irq_state[15:0] = 16'h0000;
        irq_taken[0] = 1'b1;
        tick("t3_taken");
        irq_taken[0] = 1'b0;

        // 4: halt and sleep together -> HALT, then absorbing
        halt_req[0]  = 1'b1;
        sleep_req[0] = 1'b1;
        tick("t4_halt");
        check("t4_halted", halted[0], 1'b1);
        halt_req[0] = 1'b0;
        irq_taken[0] = 1'b1;
        irq_state[15:0] = 16'hFFFF;
        for (int k = 0; k < 5; k++) tick("t4_absorb");
        check("t4_still_halted", halted[0], 1'b1);
        inputs_idle();

        // 5: divider 2, second hart sleeps then halts
        clock_divider = 32'd2;
        sleep_req[1] = 1'b1;
        sleep_pc[63:32] = 32'h0000_4444;
        for (int k = 0; k < 3; k++) tick("t5_sleep1");
        sleep_req[1] = 1'b0;
        check("t5_h1_sleeping", sleeping[1], 1'b1);
        check("t5_not_all_halted", all_halted, 1'b0);
        halt_req[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick("t5_halt1");
        halt_req[1] = 1'b0;
        check("t5_all_halted", all_halted, 1'b1);
        tick("t5_idle");

        // 6: reset while in WAKE with the divider count at 2
        do_reset();
        clock_divider = 32'd0;
        stall_in[0] = 1'b1;
        sleep_req[0] = 1'b1;
        sleep_pc[31:0] = 32'h2000;
        tick("t6_sleep");
        sleep_req[0] = 1'b0;
        irq_state[15:0] = 16'h0004;
        irq_mask[15:0]  = 16'hFFFF;
        tick("t6_wake");
        check("t6_wake_pending", wake_pending[0], 1'b1);
        check("t6_stall_d_set", stall_d[0], 1'b1);
        irq_state[15:0] = 16'h0000;
        clock_divider = 32'd3;
        for (int k = 0; k < 8 && m_since != 2; k++) tick("t6_wait");
        check("t6_count_reached", m_since == 2, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_clk_en", clk_en, 1'b1);
        check("t6_rst_state", dbg_state[1:0], ST_RUN);
        check("t6_rst_resume", resume_pc[31:0], 32'h0);
        check("t6_rst_stall", stall_d[0], 1'b0);
        check("t6_rst_wake", wake_pending[0], 1'b0);
        model_reset();
        @(negedge clk);
        check_all("t6_rst_hold");
        rst_n = 1'b1;

        // 7: randomized traffic
        inputs_idle();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 49) == 0) clock_divider = $urandom_range(0, 3);
            for (int h = 0; h < NH; h++) begin
                halt_req[h]  = ($urandom_range(0, 59) == 0);
                sleep_req[h] = ($urandom_range(0, 3) == 0);
                irq_taken[h] = ($urandom_range(0, 3) == 0);
                stall_in[h]  = $urandom_range(0, 1);
                sleep_pc[h*PC_W +: PC_W] = $urandom;
                irq_state[h*IRQ_W +: IRQ_W] =
                    ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
                irq_mask[h*IRQ_W +: IRQ_W] = 16'($urandom);
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            else tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
